// File: rtl/mem_stage.sv
// Memory-access stage: word-organised data memory with wait states,
// upstream freeze and MEM/WB output register.
module mem_stage #(
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [3:0]  dest_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] st_val_in,
  output logic        freeze,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [3:0]  dest_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_result_out
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [31:0] BASE  = 32'(BASE_ADDR);
  localparam logic [31:0] WORDS = 32'(DEPTH);
  localparam logic [CW-1:0] CNT_INIT =
    CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic HAS_WAIT = (WAIT_CYCLES > 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH];

  logic          access;
  logic          is_load;
  logic          is_store;
  logic          in_range;
  logic          done;
  logic [31:0]   off;
  logic [IW-1:0] idx;

  // Address decode and access classification
  always_comb begin
    off      = alu_result_in - BASE;
    idx      = IW'(off >> 2);
    in_range = (alu_result_in >= BASE) && ((off >> 2) < WORDS);
    access   = mem_r_en_in | mem_w_en_in;
    is_load  = mem_r_en_in;
    is_store = mem_w_en_in & ~mem_r_en_in;
    done     = (state == S_IDLE) ? (access & ~HAS_WAIT)
                                 : (cnt == '0);
  end

  // Stall upstream while the access is still counting down;
  // gated by rst so reset releases it without waiting for a clock
  always_comb begin
    freeze = 1'b0;
    if (!rst) begin
      if (state == S_IDLE) freeze = access & HAS_WAIT;
      else                 freeze = (cnt != '0);
    end
  end

  // Wait-state FSM and MEM/WB output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      wb_en_out      <= 1'b0;
      mem_r_en_out   <= 1'b0;
      dest_out       <= '0;
      alu_result_out <= '0;
      mem_result_out <= '0;
    end else if (done) begin
      state          <= S_IDLE;
      wb_en_out      <= wb_en_in;
      mem_r_en_out   <= mem_r_en_in;
      dest_out       <= dest_in;
      alu_result_out <= alu_result_in;
      mem_result_out <= (is_load && in_range) ? mem[idx] : '0;
    end else if (state == S_IDLE && !access) begin
      wb_en_out      <= wb_en_in;
      mem_r_en_out   <= mem_r_en_in;
      dest_out       <= dest_in;
      alu_result_out <= alu_result_in;
      mem_result_out <= '0;
    end else begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      if (state == S_IDLE) begin
        state <= S_WAIT;
        cnt   <= CNT_INIT;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Data memory: cleared on reset, written only on a completing store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (done && is_store && in_range) begin
      mem[idx] <= st_val_in;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage (WAIT_CYCLES=2,
// BASE_ADDR=1024, DEPTH=64).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_result_in;
  logic [31:0] st_val_in;
  logic        freeze;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_result_out;
  logic [31:0] mem_result_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        wb;
    logic [3:0]  dest;
    logic [31:0] addr;
    logic [31:0] val;
    int          frz;
    logic [31:0] res;
  } vec_t;

  vec_t vecs [18];

  mem_stage #(
    .DEPTH(64),
    .BASE_ADDR(1024),
    .WAIT_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in),
    .dest_in(dest_in),
    .alu_result_in(alu_result_in),
    .st_val_in(st_val_in),
    .freeze(freeze),
    .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out),
    .dest_out(dest_out),
    .alu_result_out(alu_result_out),
    .mem_result_out(mem_result_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outs(input string name);
    chk({name, " freeze"}, 32'(freeze), 0);
    chk({name, " wb_en"}, 32'(wb_en_out), 0);
    chk({name, " r_en"}, 32'(mem_r_en_out), 0);
    chk({name, " dest"}, 32'(dest_out), 0);
    chk({name, " alu"}, alu_result_out, 0);
    chk({name, " mres"}, mem_result_out, 0);
  endtask

  // Apply one instruction, count freeze cycles, check bubbles and
  // the registered outputs after the completion edge.
  task automatic run_op(input vec_t v, input int n);
    int  f;
    bit  fin;
    string tag;
    f   = 0;
    fin = 0;
    tag = $sformatf("v%0d", n);
    @(negedge clk);
    mem_r_en_in   = v.rd;
    mem_w_en_in   = v.wr;
    wb_en_in      = v.wb;
    dest_in       = v.dest;
    alu_result_in = v.addr;
    st_val_in     = v.val;
    for (int c = 0; c < 10 && !fin; c++) begin
      #1;
      if (!freeze) fin = 1;
      else f++;
      @(posedge clk);
      #1;
      if (!fin) begin
        checks++;
        if (wb_en_out !== 1'b0 || mem_r_en_out !== 1'b0) begin
          errors++;
          $display("FAIL %s bubble: wb=%b r_en=%b expected 0 0",
                   tag, wb_en_out, mem_r_en_out);
        end
        @(negedge clk);
      end
    end
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: freeze stuck high", tag);
    end
    chk({tag, " frz_cycles"}, 32'(f), 32'(v.frz));
    chk({tag, " wb_en"}, 32'(wb_en_out), 32'(v.wb));
    chk({tag, " r_en"}, 32'(mem_r_en_out), 32'(v.rd));
    chk({tag, " dest"}, 32'(dest_out), 32'(v.dest));
    chk({tag, " alu"}, alu_result_out, v.addr);
    if (v.rd || !v.wr)
      chk({tag, " mres"}, mem_result_out, v.res);
  endtask

  task automatic idle_inputs();
    mem_r_en_in   = 0;
    mem_w_en_in   = 0;
    wb_en_in      = 0;
    dest_in       = 0;
    alu_result_in = 0;
    st_val_in     = 0;
  endtask

  vec_t ld1024;

  initial begin
    //            rd wr wb dest addr  val            frz res
    vecs[0]  = '{0, 0, 1, 4'd5, 32'h12, 32'h0,        0, 32'h0};
    vecs[1]  = '{0, 1, 0, 4'd0, 1028, 32'hDEADBEEF,   2, 32'h0};
    vecs[2]  = '{1, 0, 1, 4'd3, 1028, 32'h0,          2, 32'hDEADBEEF};
    vecs[3]  = '{0, 1, 0, 4'd0, 1024, 32'h99,         2, 32'h0};
    vecs[4]  = '{0, 1, 0, 4'd0, 1276, 32'h1234,       2, 32'h0};
    vecs[5]  = '{1, 0, 1, 4'd4, 1276, 32'h0,          2, 32'h1234};
    vecs[6]  = '{0, 1, 0, 4'd0, 1020, 32'h11,         2, 32'h0};
    vecs[7]  = '{0, 1, 0, 4'd0, 1280, 32'h22,         2, 32'h0};
    vecs[8]  = '{1, 0, 1, 4'd6, 1020, 32'h0,          2, 32'h0};
    vecs[9]  = '{1, 0, 1, 4'd7, 1280, 32'h0,          2, 32'h0};
    vecs[10] = '{1, 0, 1, 4'd8, 1276, 32'h0,          2, 32'h1234};
    vecs[11] = '{1, 0, 1, 4'd1, 1024, 32'h0,          2, 32'h99};
    vecs[12] = '{0, 1, 0, 4'd0, 1030, 32'h55,         2, 32'h0};
    vecs[13] = '{1, 0, 1, 4'd2, 1028, 32'h0,          2, 32'h55};
    vecs[14] = '{0, 1, 0, 4'd0, 1032, 32'h7,          2, 32'h0};
    vecs[15] = '{1, 1, 1, 4'd9, 1032, 32'hFF,         2, 32'h7};
    vecs[16] = '{1, 0, 1, 4'd10, 1032, 32'h0,         2, 32'h7};
    vecs[17] = '{0, 0, 1, 4'd11, 32'hABCD, 32'h0,     0, 32'h0};
    ld1024   = '{1, 0, 1, 4'd1, 1024, 32'h0,          2, 32'h0};

    idle_inputs();
    rst = 1;
    #12;
    chk_zero_outs("reset");
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 18; i++) run_op(vecs[i], i);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk_zero_outs("rst_mid");
    @(negedge clk);
    rst = 0;
    run_op(ld1024, 100);

    // Reset while a store is in its wait states
    @(negedge clk);
    mem_r_en_in   = 0;
    mem_w_en_in   = 1;
    wb_en_in      = 0;
    dest_in       = 0;
    alu_result_in = 1024;
    st_val_in     = 32'hAA;
    #1;
    chk("acc freeze_start", 32'(freeze), 1);
    @(posedge clk);
    #3;
    chk("acc freeze_wait", 32'(freeze), 1);
    rst = 1;
    #1;
    chk("acc freeze_rst", 32'(freeze), 0);
    @(negedge clk);
    idle_inputs();
    rst = 0;
    run_op(ld1024, 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage ARM pipeline. Directly downstream of the EX stage register; consumes its wb_en, mem_r_en, mem_w_en, dest, alu_result and st_val outputs.
- Performs data-memory load/store on an internal word-organised memory. Models a configurable number of wait states and raises freeze to stall the upstream pipeline during an access.
- Registers the results into MEM/WB outputs for write-back.

Parameters:
- DEPTH, 64, number of 32-bit data-memory words (power of two).
- BASE_ADDR, 1024, byte address mapped to word 0.
- WAIT_CYCLES, 2, extra stall cycles per load/store (0 = single-cycle access).

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- wb_en_in  input  1  write-back enable from EX stage register
- mem_r_en_in  input  1  load request
- mem_w_en_in  input  1  store request
- dest_in  input  4  destination register index
- alu_result_in  input  32  byte address for load/store, or ALU result to forward
- st_val_in  input  32  store data
- freeze  output  1  combinational; 1 = upstream stages and EX register must hold
- wb_en_out  output  1  registered write-back enable
- mem_r_en_out  output  1  registered; selects mem_result_out at write-back
- dest_out  output  4  registered destination index
- alu_result_out  output  32  registered ALU result
- mem_result_out  output  32  registered load data

Behaviour:
- Reset (async, any time): all outputs 0, FSM to IDLE, wait counter 0, every memory word cleared to 0. A store in flight is not committed.
- Address mapping:
  - word index = (alu_result_in - BASE_ADDR) >> 2, using the low log2(DEPTH) bits.
  - Byte offset bits [1:0] are ignored.
  - In range iff BASE_ADDR <= alu_result_in < BASE_ADDR + 4*DEPTH. Out-of-range stores are dropped; out-of-range loads return 0.
- Access = mem_r_en_in | mem_w_en_in. If both are asserted, the load wins and the store is suppressed.
- FSM states: IDLE, WAIT. Counter width: clog2(WAIT_CYCLES+1).
- IDLE, no access: freeze=0. Every edge registers the inputs to the outputs; mem_result_out <= 0.
- IDLE, access, WAIT_CYCLES=0: freeze=0. The access completes at this edge (see completion).
- IDLE, access, WAIT_CYCLES>0: freeze=1; at the edge go to WAIT with cnt <= WAIT_CYCLES-1. Outputs register a bubble: wb_en_out=0, mem_r_en_out=0, others unchanged.
- WAIT, cnt!=0: freeze=1; cnt <= cnt-1; outputs register a bubble.
- WAIT, cnt==0: freeze=0; the access completes at this edge; go to IDLE.
- Completion edge:
  - Store: mem[index] <= st_val_in.
  - Load: mem_result_out <= mem[index], the value before any same-edge write.
  - Outputs register wb_en_in, mem_r_en_in, dest_in and alu_result_in.
- Latency: each load/store occupies exactly WAIT_CYCLES+1 cycles. freeze is high for the first WAIT_CYCLES of them. Non-memory instructions take 1 cycle.
- Upstream holds all inputs stable while freeze=1. Input changes during WAIT are not sampled until the completion edge; the memory index is taken at completion.
- Back-to-back accesses: the cycle after completion is IDLE, so a new access starts immediately with no dead cycle.
- Reset during WAIT: immediate return to IDLE, freeze deasserts asynchronously, memory cleared.

Test Plan:
- Reset: assert rst mid-run → all outputs 0, freeze=0; a load from 1024 afterwards returns 0.
- Store then load, WAIT_CYCLES=2:
  - Store st_val=0xDEADBEEF to 1028 → freeze high for 2 cycles, then low.
  - Load from 1028 → after 3 cycles mem_result_out=0xDEADBEEF, mem_r_en_out=1; wb_en_out=0 on the 2 bubble cycles.
- Non-memory op: wb_en_in=1, dest_in=5, alu_result_in=0x12 with no access → next edge wb_en_out=1, dest_out=5, alu_result_out=0x12, freeze never asserted.
- Address boundaries:
  - Store to 1020 and to 1024+4*DEPTH=1280 → both dropped; loads return 0.
  - Store to 1276 → last word written, read back matches.
  - Store 0x55 to 1030 → lands in word 1.
- Simultaneous enables: mem_r_en_in=mem_w_en_in=1 at 1032 holding 0x7 → load returns 0x7, memory unchanged.
- Reset mid-access: issue a store of 0xAA to 1024, assert rst during WAIT → freeze drops immediately; a subsequent load from 1024 returns 0.
